serial_link_arbiter: RTL and testbench
======================================

// Module: serial_link_arbiter
// PURPOSE
// - Shares one serial output pin between NUM_REQ parallel byte sources: SAP-3 output register, register-file dump, etc.
// - Round-robin arbitration; the granted word is latched and sent as a frame: source ID header, then data MSB-first, then idle gap.
// - Sits at chip top between the SAP-3 core and uo_out. It replaces the per-source serializers and frees output pins.
// PARAMETERS
// - WIDTH       8  data bits per frame
// - NUM_REQ     2  number of requesters (>=2)
// - GAP_CYCLES  1  bit-slots of forced-low idle after each frame (0 = back-to-back frames allowed)
// PORTS
// - clk          in   1                single clock; all state on rising edge
// - rst_n        in   1                asynchronous, active-low reset
// - bit_en       in   1                bit-slot strobe (e.g. divided-clock tick); state advances only when 1
// - req          in   NUM_REQ          level request per source; hold high with stable data until ack
// - data         in   NUM_REQ*WIDTH    packed words; source i = data[i*WIDTH +: WIDTH]
// - ack          out  NUM_REQ          one-clk pulse: source i's word has been latched
// - serial_out   out  1                serial line
// - frame_start  out  1                high during first header bit of each frame
// - busy         out  1                high in any state other than IDLE
// - grant_id     out  ID_W             ID of source currently or last served; ID_W = $clog2(NUM_REQ)
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE; serial_out=0; frame_start=0; ack=0; busy=0; grant_id=0; rr pointer=NUM_REQ-1, so source 0 wins first.
// - FSM: IDLE -> HDR (ID_W bits) -> DATA (WIDTH bits) -> GAP (GAP_CYCLES bits) -> IDLE. GAP is skipped when GAP_CYCLES=0.
// - Every transition and every bit shift requires bit_en=1. With bit_en=0 all registers hold, except that ack always clears after one clk.
// - IDLE with bit_en=1 and |req: winner is the first asserted req searching from (ptr+1) mod NUM_REQ.
//   - Same edge: latch {winner_id, data[winner]} into the shift register; ptr<=winner; grant_id<=winner; ack[winner]<=1; state<=HDR.
//   - The first header bit appears on serial_out in the clk following the grant edge. Latency is 1 clk from the sampling edge.
// - HDR: serial_out = grant_id MSB-first, one bit per bit_en slot; frame_start=1 only during the first HDR slot.
// - DATA: serial_out = latched word MSB-first, WIDTH slots.
// - GAP: serial_out=0 for GAP_CYCLES slots. In IDLE serial_out=0.
// - Frame length is ID_W+WIDTH slots, plus the gap.
// - Changes to req/data after the grant edge do not affect the frame in flight.
// - req is sampled only in IDLE. A req still high when IDLE is re-entered counts as a new request.
//   - So a requester must drop req within ID_W+WIDTH+GAP_CYCLES slots after ack, or its word is sent again.
// - Simultaneous requests: strict round-robin, no starvation. Each of N continuously-asserted sources is served once per N frames.
// - Single requester: served every frame, back-to-back (spaced by gap).
// - req arriving mid-frame waits for IDLE; this is the only arbitration point.
// - Reset mid-frame: frame aborted at once, line low, ptr reset. The partially sent word is lost even if its ack was already given.
// - Counter widths: bit counter is $clog2(max(ID_W+WIDTH, GAP_CYCLES)+1) bits. The count compares to the terminal value; no wrap dependence.
// STRUCTURE
// - Package sap3_link_pkg holds: typedef enum logic [1:0] {IDLE, HDR, DATA, GAP} link_state_t; function clog2_min1 (gives ID_W>=1).
// - Sub-module rr_arbiter #(N): inputs req, ptr; outputs gnt_valid and gnt_id.
//   - rr_arbiter is purely combinational and holds the round-robin priority search.
// - The top holds the FSM, the shift register (ID_W+WIDTH bits), the bit counter, ack and the pointer registers.
// TESTING
// - Reset, then req=2'b01, data0=8'hA5, bit_en=1:
//   - ack[0] 1 clk after the sampling edge; frame_start on the first bit; serial bits 0,1,0,1,0,0,1,0,1; busy for 10 clks; then line low.
// - req=2'b11 held, data0=8'h00, data1=8'hFF:
//   - frame order is ID0, ID1, ID0, ID1; ack alternates; grant_id tracks the order; one gap slot between frames.
// - bit_en=1 every 4th clk, single request 8'h3C:
//   - each bit is held exactly 4 clks; the ack pulse is still 1 clk wide; the frame occupies 36 clks.
// - Change data0 from 8'h11 to 8'hEE one clk after ack[0]:
//   - the serialized word is 8'h11; req0 still high at IDLE gives a second frame carrying 8'hEE.
// - Assert rst_n=0 during the 4th data bit:
//   - serial_out, busy and frame_start go 0 without waiting for a clk edge.
//   - After release with req=2'b10 pending, source 1 is served (ptr restarts at NUM_REQ-1, so search begins at 0; req0 is low).
// - GAP_CYCLES=0 build with req=2'b01 held: frames are contiguous, frame_start every 9 slots, no idle slot.

Source files
------------

// File: rtl/sap3_link_pkg.sv
// Shared types and helpers for the serial link arbiter.
package sap3_link_pkg;

    typedef enum logic [1:0] {IDLE, HDR, DATA, GAP} link_state_t;

    // ID width that never collapses to zero, so a 1-bit header exists even for tiny N
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: round-robin priority search starting one past the last winner.
// Latency: combinational.
// Backpressure: none; the caller decides when the grant is taken.
module rr_arbiter
    import sap3_link_pkg::*;
#(
    parameter  int N    = 2,
    localparam int ID_W = clog2_min1(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            gnt_valid,
    output logic [ID_W-1:0] gnt_id
);

    logic [ID_W-1:0] idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        idx       = '0;
        for (int k = 1; k <= N; k++) begin
            idx = ID_W'((32'(ptr) + 32'(k)) % 32'(N));
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_id    = idx;
            end
        end
    end

endmodule

// File: rtl/serial_link_arbiter.sv
// Purpose: shares one serial pin among NUM_REQ byte sources; frame = ID header, data MSB-first, idle gap.
// Latency: first header bit on serial_out 1 clk after the granting bit_en edge; ack pulses on that same clk.
// Backpressure: requesters hold req/data until ack; req is only sampled at frame boundaries.
module serial_link_arbiter
    import sap3_link_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int NUM_REQ    = 2,
    parameter  int GAP_CYCLES = 1,
    localparam int ID_W       = clog2_min1(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     bit_en,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] data,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     serial_out,
    output logic                     frame_start,
    output logic                     busy,
    output logic [ID_W-1:0]          grant_id
);

    localparam int SH_W    = ID_W + WIDTH;
    localparam int CNT_MAX = (SH_W > GAP_CYCLES) ? SH_W : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Counter runs continuously through header and data, restarts for the gap
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ID_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(SH_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    link_state_t      state, state_nxt;
    logic [SH_W-1:0]  shreg;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  ptr;
    logic             gnt_valid;
    logic [ID_W-1:0]  gnt_id;
    logic             arb, load, shift, cnt_clr, cnt_inc;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req       (req),
        .ptr       (ptr),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        arb         = 1'b0;
        load        = 1'b0;
        shift       = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        serial_out  = 1'b0;
        frame_start = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE: arb = bit_en;
            HDR: begin
                serial_out  = shreg[SH_W-1];
                frame_start = (cnt == '0);
                if (bit_en) begin
                    shift   = 1'b1;
                    cnt_inc = 1'b1;
                    if (cnt == HDR_LAST) state_nxt = DATA;
                end
            end
            DATA: begin
                serial_out = shreg[SH_W-1];
                if (bit_en) begin
                    shift = 1'b1;
                    if (cnt == DATA_LAST) begin
                        cnt_clr = 1'b1;
                        if (GAP_CYCLES == 0) arb = 1'b1;
                        else                 state_nxt = GAP;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            GAP: begin
                if (bit_en) begin
                    if (cnt == GAP_LAST) begin
                        cnt_clr = 1'b1;
                        arb     = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Frame boundary doubles as the arbitration point so frames can run back-to-back
        if (arb) begin
            cnt_clr = 1'b1;
            if (gnt_valid) begin
                load      = 1'b1;
                state_nxt = HDR;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            cnt      <= '0;
            ptr      <= ID_W'(NUM_REQ - 1);
            grant_id <= '0;
            ack      <= '0;
        end else begin
            ack <= '0;
            if (load) begin
                shreg       <= {gnt_id, data[gnt_id*WIDTH +: WIDTH]};
                ptr         <= gnt_id;
                grant_id    <= gnt_id;
                ack[gnt_id] <= 1'b1;
            end else if (shift) begin
                shreg <= {shreg[SH_W-2:0], 1'b0};
            end
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_link_arbiter.sv
// Bench for serial_link_arbiter: slot-queue reference model plus directed frame checks.
module tb_serial_link_arbiter;

    localparam int NR  = 2;
    localparam int W   = 8;
    localparam int GAP = 1;
    localparam int IDW = 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            bit_en;
    logic [NR-1:0]   req;
    logic [NR*W-1:0] data;
    logic [NR-1:0]   ack;
    logic            serial_out, frame_start, busy;
    logic [IDW-1:0]  grant_id;

    logic [NR-1:0]   req_z;
    logic [NR*W-1:0] data_z;
    logic [NR-1:0]   ack_z;
    logic            serial_z, frame_start_z, busy_z;
    logic [IDW-1:0]  grant_id_z;

    always #5 clk = ~clk;

    serial_link_arbiter #(.WIDTH(W), .NUM_REQ(NR), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .req(req), .data(data),
        .ack(ack), .serial_out(serial_out), .frame_start(frame_start),
        .busy(busy), .grant_id(grant_id)
    );

    serial_link_arbiter #(.WIDTH(W), .NUM_REQ(NR), .GAP_CYCLES(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .req(req_z), .data(data_z),
        .ack(ack_z), .serial_out(serial_z), .frame_start(frame_start_z),
        .busy(busy_z), .grant_id(grant_id_z)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: the expected line contents as a queue of pending bit slots
    typedef struct packed {logic b; logic first;} slot_t;
    slot_t         q[$];
    int            m_ptr;
    int            m_gid;
    logic [NR-1:0] exp_ack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int win;
        logic [W-1:0] wd;
        slot_t s;
        exp_ack = '0;
        if (bit_en) begin
            if (q.size() != 0) void'(q.pop_front());
            if (q.size() == 0) begin
                win = -1;
                for (int k = 1; k <= NR; k++) begin
                    if (win < 0 && req[(m_ptr + k) % NR]) win = (m_ptr + k) % NR;
                end
                if (win >= 0) begin
                    m_ptr = win;
                    m_gid = win;
                    exp_ack[win] = 1'b1;
                    wd = data[win*W +: W];
                    for (int b = IDW - 1; b >= 0; b--) begin
                        s.b = ((win >> b) & 1) != 0;
                        s.first = (b == IDW - 1);
                        q.push_back(s);
                    end
                    for (int b = W - 1; b >= 0; b--) begin
                        s.b = wd[b];
                        s.first = 1'b0;
                        q.push_back(s);
                    end
                    for (int g = 0; g < GAP; g++) q.push_back(slot_t'(2'b00));
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic e_ser, e_fs, e_busy;
        e_busy = (q.size() != 0);
        e_ser  = e_busy ? q[0].b : 1'b0;
        e_fs   = e_busy ? q[0].first : 1'b0;
        chk("serial_out", serial_out, e_ser);
        chk("frame_start", frame_start, e_fs);
        chk("busy", busy, e_busy);
        chk("ack", ack, exp_ack);
        chk("grant_id", grant_id, m_gid);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        m_ptr   = NR - 1;
        m_gid   = 0;
        exp_ack = '0;
        #2;
        check_outputs();
        chk("z_serial_rst", serial_z, 0);
        chk("z_busy_rst", busy_z, 0);
        chk("z_ack_rst", ack_z, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        bit_en = 1'b0;
        req    = '0;
        data   = '0;
        req_z  = '0;
        data_z = '0;
        do_reset();
        bit_en = 1'b1;
        tick();

        // Single frame of A5 from source 0
        begin : t1
            logic [8:0] bits;
            int nb;
            bits = '0;
            nb   = 0;
            data[7:0] = 8'hA5;
            req = 2'b01;
            tick();
            chk("t1_ack", ack, 2'b01);
            req = '0;
            for (int i = 0; i < 12; i++) begin
                if (i < 9) bits[8-i] = serial_out;
                if (busy) nb++;
                tick();
            end
            chk("t1_bits", bits, 9'b010100101);
            chk("t1_busy_clks", nb, 10);
        end

        // Two continuous requesters alternate
        begin : t2
            int n;
            int last;
            n = 0;
            last = 0;
            do_reset();
            data = {8'hFF, 8'h00};
            req  = 2'b11;
            for (int c = 0; c < 60 && n < 4; c++) begin
                tick();
                if (ack != '0) begin
                    chk("t2_order", ack, (n % 2 == 0) ? 2'b01 : 2'b10);
                    chk("t2_grant", grant_id, n % 2);
                    if (n > 0) chk("t2_spacing", c - last, 10);
                    last = c;
                    n++;
                end
            end
            chk("t2_frames", n, 4);
            req = '0;
            for (int i = 0; i < 12; i++) tick();
        end

        // Slow bit strobe: one slot every 4 clks
        begin : t3
            int nack, nbusy, nfs;
            nack = 0;
            nbusy = 0;
            nfs = 0;
            data[7:0] = 8'h3C;
            req = 2'b01;
            for (int c = 0; c < 48; c++) begin
                bit_en = (c % 4 == 0);
                tick();
                if (ack != '0) begin
                    nack++;
                    req = '0;
                end
                if (busy) nbusy++;
                if (frame_start) nfs++;
            end
            chk("t3_ack_clks", nack, 1);
            chk("t3_busy_clks", nbusy, 40);
            chk("t3_first_slot_clks", nfs, 4);
            bit_en = 1'b1;
        end

        // Data changed after grant must not affect the frame in flight
        begin : t4
            logic [W-1:0] w1, w2;
            w1 = '0;
            w2 = '0;
            data[7:0] = 8'h11;
            req = 2'b01;
            for (int c = 0; c < 22; c++) begin
                tick();
                if (c == 0) begin
                    chk("t4_ack1", ack, 2'b01);
                    data[7:0] = 8'hEE;
                end
                if (c >= 1 && c <= 8) w1[8-c] = serial_out;
                if (c == 10) begin
                    chk("t4_ack2", ack, 2'b01);
                    req = '0;
                end
                if (c >= 11 && c <= 18) w2[18-c] = serial_out;
            end
            chk("t4_word1", w1, 8'h11);
            chk("t4_word2", w2, 8'hEE);
        end

        // Reset during the 4th data bit, then source 1 pending
        begin : t5
            data[7:0] = 8'hFF;
            req = 2'b01;
            tick();
            chk("t5_ack0", ack, 2'b01);
            req = '0;
            for (int i = 0; i < 4; i++) tick();
            chk("t5_pre_reset_line", serial_out, 1);
            do_reset();
            req = 2'b10;
            data[15:8] = 8'h96;
            tick();
            chk("t5_ack1", ack, 2'b10);
            chk("t5_gid", grant_id, 1);
            req = '0;
            for (int i = 0; i < 12; i++) tick();
        end

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = 2'($urandom_range(0, 3));
            data   = 16'($urandom);
            bit_en = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 199) == 0) do_reset();
            tick();
        end
        req    = '0;
        bit_en = 1'b1;
        for (int i = 0; i < 12; i++) tick();

        // Zero-gap build: contiguous frames from one held requester
        begin : tz
            logic [8:0] patz;
            int found;
            patz = {1'b0, 8'h5A};
            found = 0;
            data_z[7:0] = 8'h5A;
            req_z = 2'b01;
            for (int c = 0; c < 5 && found == 0; c++) begin
                tick();
                if (frame_start_z) found = 1;
            end
            chk("z_start_seen", found, 1);
            if (found != 0) begin
                for (int c = 0; c < 27; c++) begin
                    chk("z_serial", serial_z, patz[8-(c%9)]);
                    chk("z_frame_start", frame_start_z, (c % 9 == 0) ? 1 : 0);
                    chk("z_busy", busy_z, 1);
                    chk("z_ack", ack_z, (c % 9 == 0) ? 2'b01 : 2'b00);
                    tick();
                end
            end
            req_z = '0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
